equilibrium_game_uc: RTL and testbench

Parametrised game control unit for the EquilibriumMaxxing platform: sequences calibration, level selection, preparation, move generation and play. It counts rounds and hits per level, promotes the level automatically and ends the game with a win or loss verdict. It adds a calibration timeout, pause/abort handling and an internal preparation timer. It sits between the input/sensor front-end and the datapath (move generator, servo driver, fade/LED effects).

---
 rtl/equilibrium_pkg.sv | 22 ++
 rtl/em_cycle_counter.sv | 19 +
 rtl/equilibrium_game_uc.sv | 141 ++++++++++++++
 tb/tb_equilibrium_game_uc.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/equilibrium_pkg.sv
// equilibrium_pkg: game state encoding shared by the control unit, the datapath and the display decoder.
package equilibrium_pkg;
    localparam int DB_W = 4;
    localparam logic [DB_W-1:0] ST_CALIBRA   = 4'd0;
    localparam logic [DB_W-1:0] ST_CAL_ERR   = 4'd1;
    localparam logic [DB_W-1:0] ST_SEL_NIVEL = 4'd2;
    localparam logic [DB_W-1:0] ST_PREP      = 4'd3;
    localparam logic [DB_W-1:0] ST_GEN_NEXT  = 4'd4;
    localparam logic [DB_W-1:0] ST_JOGA      = 4'd5;
    localparam logic [DB_W-1:0] ST_PAUSA     = 4'd6;
    localparam logic [DB_W-1:0] ST_FIM       = 4'd7;
    typedef enum logic [DB_W-1:0] {
        CALIBRA   = ST_CALIBRA,
        CAL_ERR   = ST_CAL_ERR,
        SEL_NIVEL = ST_SEL_NIVEL,
        PREP      = ST_PREP,
        GEN_NEXT  = ST_GEN_NEXT,
        JOGA      = ST_JOGA,
        PAUSA     = ST_PAUSA,
        FIM       = ST_FIM
    } state_t;
endpackage

// File: rtl/em_cycle_counter.sv
// em_cycle_counter: saturating cycle counter; done is high once MAX cycles have been counted.
module em_cycle_counter #(
    parameter int MAX = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic done
);
    localparam int W = MAX > 1 ? $clog2(MAX) : 1;
    localparam logic [W-1:0] LAST = W'(MAX - 1);
    logic [W-1:0] cnt_q;
    always_ff @(posedge clock or negedge reset)
        if (!reset) cnt_q <= '0;
        else if (clear) cnt_q <= '0;
        else if (enable && !done) cnt_q <= cnt_q + 1'b1;
    assign done = cnt_q == LAST;
endmodule

// File: rtl/equilibrium_game_uc.sv
// equilibrium_game_uc: game sequencer -- calibration, level select, prep timer, move request, play,
// round/hit scoring with automatic level promotion and win/loss verdict.
module equilibrium_game_uc
    import equilibrium_pkg::*;
#(
    parameter int NUM_LEVELS       = 4,
    parameter int ROUNDS_PER_LEVEL = 8,
    parameter int PASS_HITS        = 6,
    parameter int PREP_CYCLES      = 1000,
    parameter int CAL_TIMEOUT      = 50_000_000,
    localparam int LW = NUM_LEVELS > 2 ? $clog2(NUM_LEVELS) : 1,
    localparam int RW = $clog2(ROUNDS_PER_LEVEL + 1)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start_game,
    input  logic [LW-1:0]   nivel_sel,
    input  logic            sensor_fim_curso,
    input  logic            ponto_evento,
    input  logic            ponto_acerto,
    input  logic            pause_req,
    input  logic            abort,
    output logic            gerar_nova_jogada,
    output logic            fade_trigger,
    output logic            trava_servo,
    output logic            calib,
    output logic            cal_erro,
    output logic            external,
    output logic            game_over,
    output logic            venceu,
    output logic [LW-1:0]   nivel_atual,
    output logic [RW-1:0]   rodada,
    output logic [RW-1:0]   acertos,
    output logic [DB_W-1:0] db_estado
);
    localparam logic [LW-1:0] TOP_LVL = LW'(NUM_LEVELS - 1);
    localparam logic [RW-1:0] RPL     = RW'(ROUNDS_PER_LEVEL);
    localparam logic [RW-1:0] PASS    = RW'(PASS_HITS);

    state_t        state_q, ret_q;
    logic [LW-1:0] nivel_q;
    logic [RW-1:0] rodada_q, acertos_q, rodada_d, acertos_d;
    logic          venceu_q, fade_q;
    logic          prep_done, cal_done, abort_ok, last_round, passed;
    logic [LW-1:0] sel_clamped;

    assign rodada_d    = rodada_q + 1'b1;
    assign acertos_d   = acertos_q + RW'(ponto_acerto);
    assign last_round  = rodada_d >= RPL;
    assign passed      = acertos_d >= PASS;
    assign sel_clamped = nivel_sel > TOP_LVL ? TOP_LVL : nivel_sel;
    assign abort_ok    = abort && state_q != CALIBRA && state_q != CAL_ERR;

    // Prep timer holds its count through PAUSA so a paused preparation resumes where it stopped.
    em_cycle_counter #(.MAX(PREP_CYCLES)) u_prep (
        .clock (clock),
        .reset (reset),
        .clear (state_q != PREP && state_q != PAUSA),
        .enable(state_q == PREP),
        .done  (prep_done)
    );

    em_cycle_counter #(.MAX(CAL_TIMEOUT)) u_cal (
        .clock (clock),
        .reset (reset),
        .clear (state_q != CALIBRA),
        .enable(state_q == CALIBRA),
        .done  (cal_done)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= CALIBRA;
            ret_q     <= PREP;
            nivel_q   <= '0;
            rodada_q  <= '0;
            acertos_q <= '0;
            venceu_q  <= 1'b0;
            fade_q    <= 1'b0;
        end else begin
            fade_q <= state_q == GEN_NEXT && !abort_ok;
            if (abort_ok) begin
                state_q   <= SEL_NIVEL;
                rodada_q  <= '0;
                acertos_q <= '0;
                venceu_q  <= 1'b0;
            end else if (state_q == JOGA && ponto_evento) begin
                if (!last_round) begin
                    state_q   <= PREP;
                    rodada_q  <= rodada_d;
                    acertos_q <= acertos_d;
                end else if (passed && nivel_q != TOP_LVL) begin
                    state_q   <= PREP;
                    nivel_q   <= nivel_q + 1'b1;
                    rodada_q  <= '0;
                    acertos_q <= '0;
                end else begin
                    state_q   <= FIM;
                    venceu_q  <= passed;
                    rodada_q  <= rodada_d;
                    acertos_q <= acertos_d;
                end
            end else if (pause_req && (state_q == PREP || state_q == JOGA)) begin
                ret_q   <= state_q;
                state_q <= PAUSA;
            end else begin
                case (state_q)
                    CALIBRA:   if (sensor_fim_curso) state_q <= SEL_NIVEL;
                               else if (cal_done) state_q <= CAL_ERR;
                    CAL_ERR:   if (start_game) state_q <= CALIBRA;
                    SEL_NIVEL: if (start_game) begin
                        state_q   <= PREP;
                        nivel_q   <= sel_clamped;
                        rodada_q  <= '0;
                        acertos_q <= '0;
                        venceu_q  <= 1'b0;
                    end
                    PREP:      if (prep_done) state_q <= GEN_NEXT;
                    GEN_NEXT:  state_q <= JOGA;
                    JOGA:      state_q <= JOGA;
                    PAUSA:     if (!pause_req) state_q <= ret_q;
                    FIM:       if (start_game) state_q <= SEL_NIVEL;
                    default:   state_q <= CALIBRA;
                endcase
            end
        end
    end

    assign gerar_nova_jogada = state_q == GEN_NEXT;
    assign fade_trigger      = fade_q;
    assign trava_servo       = state_q == SEL_NIVEL || state_q == PAUSA || state_q == FIM;
    assign calib             = state_q == CALIBRA;
    assign cal_erro          = state_q == CAL_ERR;
    assign external          = state_q == PREP || state_q == GEN_NEXT || state_q == JOGA;
    assign game_over         = state_q == FIM;
    assign venceu            = venceu_q;
    assign nivel_atual       = nivel_q;
    assign rodada            = rodada_q;
    assign acertos           = acertos_q;
    assign db_estado         = state_q;
endmodule

// File: tb/tb_equilibrium_game_uc.sv
// tb_equilibrium_game_uc: directed stimulus with a cycle-level game model checked every clock,
// plus literal expectations at the key points of each scenario.
module tb_equilibrium_game_uc;
    localparam int NL = 2, R = 2, PH = 2, P = 3, CT = 10;

    logic clock = 0, reset = 0;
    logic start_game = 0, sensor = 0, ev = 0, hit = 0, pause = 0, abort = 0;
    logic [0:0] nsel = 0;
    logic gerar, fade, trava, calib, cal_erro, external, game_over, venceu;
    logic [0:0] nivel;
    logic [1:0] rodada, acertos;
    logic [3:0] db_estado;

    logic t3_start = 0, t3_sensor = 0;
    logic [1:0] t3_sel = 0;
    logic t3_gerar, t3_fade, t3_trava, t3_calib, t3_cal_erro, t3_ext, t3_go, t3_venceu;
    logic [1:0] t3_nivel, t3_rodada, t3_acertos;
    logic [3:0] t3_db;

    int checks = 0, passes = 0, gen_cnt = 0, prep_seen = 0;
    int m_st = 0, m_ret = 0, m_cal = 0, m_prep = 0, m_lvl = 0, m_rod = 0, m_ac = 0, m_win = 0, m_fade = 0;
    logic [16:0] exp_v, act_v;

    always #5 clock = ~clock;

    equilibrium_game_uc #(.NUM_LEVELS(NL), .ROUNDS_PER_LEVEL(R), .PASS_HITS(PH),
                          .PREP_CYCLES(P), .CAL_TIMEOUT(CT)) dut (
        .clock(clock), .reset(reset), .start_game(start_game), .nivel_sel(nsel),
        .sensor_fim_curso(sensor), .ponto_evento(ev), .ponto_acerto(hit),
        .pause_req(pause), .abort(abort), .gerar_nova_jogada(gerar), .fade_trigger(fade),
        .trava_servo(trava), .calib(calib), .cal_erro(cal_erro), .external(external),
        .game_over(game_over), .venceu(venceu), .nivel_atual(nivel), .rodada(rodada),
        .acertos(acertos), .db_estado(db_estado));

    equilibrium_game_uc #(.NUM_LEVELS(3), .ROUNDS_PER_LEVEL(R), .PASS_HITS(PH),
                          .PREP_CYCLES(P), .CAL_TIMEOUT(1000)) dut3 (
        .clock(clock), .reset(reset), .start_game(t3_start), .nivel_sel(t3_sel),
        .sensor_fim_curso(t3_sensor), .ponto_evento(1'b0), .ponto_acerto(1'b0),
        .pause_req(1'b0), .abort(1'b0), .gerar_nova_jogada(t3_gerar), .fade_trigger(t3_fade),
        .trava_servo(t3_trava), .calib(t3_calib), .cal_erro(t3_cal_erro), .external(t3_ext),
        .game_over(t3_go), .venceu(t3_venceu), .nivel_atual(t3_nivel), .rodada(t3_rodada),
        .acertos(t3_acertos), .db_estado(t3_db));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act === expv) passes++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic wait_st(input logic [3:0] s, input string nm);
        int n = 0;
        while (db_estado !== s && n < 60) begin
            @(negedge clock);
            n++;
        end
        chk(nm, 32'(db_estado), 32'(s));
    endtask

    task automatic play(input logic h);
        wait_st(4'd5, "reach_joga");
        ev = 1; hit = h;
        tick(1);
        ev = 0; hit = 0;
    endtask

    task automatic pulse_start();
        start_game = 1;
        tick(1);
        start_game = 0;
    endtask

    // Game model: states by number, elapsed-cycle counters, scoring from the rules.
    initial forever begin
        @(posedge clock or negedge reset);
        if (!reset) begin
            m_st = 0; m_ret = 0; m_cal = 0; m_prep = 0; m_lvl = 0;
            m_rod = 0; m_ac = 0; m_win = 0; m_fade = 0;
        end else begin
            m_fade = 0;
            if (abort && m_st > 1) begin
                m_st = 2; m_rod = 0; m_ac = 0; m_win = 0;
            end else case (m_st)
                0: begin
                    m_cal++;
                    if (sensor) begin m_st = 2; m_cal = 0; end
                    else if (m_cal >= CT) begin m_st = 1; m_cal = 0; end
                end
                1: if (start_game) m_st = 0;
                2: if (start_game) begin
                    m_st = 3; m_lvl = int'(nsel) > NL - 1 ? NL - 1 : int'(nsel);
                    m_rod = 0; m_ac = 0; m_win = 0; m_prep = 0;
                end
                3: begin
                    m_prep++;
                    if (pause) begin m_ret = 3; m_st = 6; end
                    else if (m_prep >= P) begin m_st = 4; m_prep = 0; end
                end
                4: begin m_st = 5; m_fade = 1; end
                5: if (ev) begin
                    m_rod++;
                    m_ac += int'(hit);
                    if (m_rod < R) m_st = 3;
                    else if (m_ac >= PH && m_lvl < NL - 1) begin m_lvl++; m_rod = 0; m_ac = 0; m_st = 3; end
                    else begin m_st = 7; m_win = m_ac >= PH ? 1 : 0; end
                end else if (pause) begin m_ret = 5; m_st = 6; end
                6: if (!pause) m_st = m_ret;
                7: if (start_game) m_st = 2;
                default: m_st = 0;
            endcase
        end
        if (clock) begin
            #1;
            exp_v = {4'(m_st), m_st == 4, m_fade == 1, m_st == 2 || m_st == 6 || m_st == 7,
                     m_st == 0, m_st == 1, m_st >= 3 && m_st <= 5, m_st == 7, m_win == 1,
                     1'(m_lvl), 2'(m_rod), 2'(m_ac)};
            act_v = {db_estado, gerar, fade, trava, calib, cal_erro, external, game_over,
                     venceu, nivel, rodada, acertos};
            chk("model", 32'(act_v), 32'(exp_v));
            if (gerar) gen_cnt++;
            if (db_estado == 4'd3) prep_seen++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        tick(2);
        chk("reset_outputs", 32'({db_estado, gerar, fade, trava, calib, cal_erro, external,
                                  game_over, venceu, nivel, rodada, acertos}), 32'h00200);
        reset = 1;
        tick(9);
        chk("cal_before_timeout", 32'({calib, cal_erro}), 32'b10);
        tick(1);
        chk("cal_timeout", 32'({calib, cal_erro}), 32'b01);
        pulse_start();
        chk("recalibrate", 32'(db_estado), 32'd0);
        sensor = 1;
        tick(1);
        sensor = 0;
        chk("sel_nivel", 32'({db_estado, trava}), 32'h5);

        base = gen_cnt;
        nsel = 0;
        pulse_start();
        chk("prep_entry", 32'({db_estado, external}), 32'h7);
        tick(3);
        chk("gen_after_prep", 32'(gerar), 32'd1);
        tick(1);
        chk("fade_first_joga", 32'({db_estado, fade}), 32'hB);
        play(1);
        play(1);
        chk("level_up", 32'({nivel, rodada, acertos}), 32'b1_00_00);
        play(1);
        play(1);
        chk("win", 32'({db_estado, game_over, venceu, nivel}), 32'b0111_1_1_1);
        chk("gen_pulses", 32'(gen_cnt - base), 32'd4);

        pulse_start();
        chk("fim_to_sel", 32'(db_estado), 32'd2);
        pulse_start();
        play(1);
        play(0);
        chk("loss", 32'({db_estado, venceu, rodada, acertos}), 32'b0111_0_10_01);

        pulse_start();
        base = prep_seen;
        start_game = 1;
        tick(1);
        start_game = 0;
        tick(1);
        pause = 1;
        tick(1);
        chk("pause_in_prep", 32'({db_estado, trava}), 32'hD);
        tick(4);
        pause = 0;
        wait_st(4'd4, "gen_after_pause");
        chk("prep_active_cycles", 32'(prep_seen - base), 32'd3);
        tick(2);
        pause = 1;
        tick(2);
        chk("pause_in_joga", 32'(db_estado), 32'd6);
        pause = 0;
        tick(1);
        chk("resume_joga_no_fade", 32'({db_estado, fade, gerar}), 32'b0101_0_0);
        ev = 1; hit = 1; pause = 1;
        tick(1);
        ev = 0; hit = 0;
        chk("event_beats_pause", 32'({db_estado, rodada, acertos}), 32'b0011_01_01);
        tick(1);
        chk("pause_after_event", 32'(db_estado), 32'd6);
        pause = 0;
        tick(1);
        chk("back_to_prep", 32'(db_estado), 32'd3);
        wait_st(4'd5, "joga_before_abort");
        abort = 1;
        tick(1);
        abort = 0;
        chk("abort_joga", 32'({db_estado, rodada, acertos, venceu}), 32'b0010_00_00_0);

        pulse_start();
        wait_st(4'd5, "joga_before_reset");
        reset = 0;
        tick(1);
        chk("reset_mid_game", 32'({db_estado, gerar, fade, trava, calib, cal_erro, external,
                                   game_over, venceu, nivel, rodada, acertos}), 32'h00200);
        tick(1);
        reset = 1;
        base = gen_cnt;
        tick(3);
        chk("no_pulse_after_reset", 32'({gen_cnt - base, 4'(db_estado)}), 32'h0);

        t3_sensor = 1;
        tick(1);
        t3_sensor = 0;
        t3_sel = 3;
        t3_start = 1;
        tick(1);
        t3_start = 0;
        chk("level_clamp", 32'({t3_db, t3_nivel}), 32'b0011_10);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
